wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural state for the interrupt-capable pipelined CPU. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to either the 32-entry general register file or the coprocessor-0 registers, selected by destination bit 5. It also serves the decode-stage read ports and the mfc0 read port, and applies interrupt entry and eret updates to Status, Cause and EPC.

## Interface
- No parameters. Data width is fixed at 32 bits, GPR count at 32, and implemented c0 registers at 3 (12 Status, 13 Cause, 14 EPC).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- RegWrite_i  in  1  write-back enable from MEM/WB.
- RegData_i  in  2  source select: 00 ALU, 01 memory, 10/11 reserved (treated as ALU).
- ALUResult_i  in  32  ALU result from MEM/WB.
- MemData_i  in  32  load data from MEM/WB.
- Rd_i  in  6  destination: bit5=0 GPR[Rd_i[4:0]], bit5=1 c0[Rd_i[4:0]].
- c0Data_i  in  32  c0 value carried for mfc0.
- mfc0_i  in  1  overrides RegData_i; write-back value is c0Data_i.
- rs_addr_i, rt_addr_i  in  5  decode read addresses.
- c0_addr_i  in  5  c0 read address for the mfc0 path.
- intr_i  in  1  interrupt entry strobe.
- epc_i  in  32  return PC captured on intr_i.
- cause_i  in  32  cause value captured on intr_i.
- eret_i  in  1  exception-return strobe.
- rs_data_o, rt_data_o  out  32  GPR read data, combinational.
- c0_rdata_o  out  32  c0 read data, combinational; 0 for unimplemented indices.
- wb_data_o  out  32  selected write-back value, combinational.
- status_o, epc_o  out  32  current Status and EPC.
- intr_en_o  out  1  Status[0].

## Operation
- Write-back select: wb_data_o = mfc0_i ? c0Data_i : (RegData_i==01 ? MemData_i : ALUResult_i).
- GPR commit: on posedge, if RegWrite_i and Rd_i[5]==0 and Rd_i[4:0]!=0, GPR[Rd_i[4:0]] <= wb_data_o. Writes to GPR0 are discarded. GPR0 always reads 0.
- c0 commit (mtc0): on posedge, if RegWrite_i and Rd_i[5]==1:
  - index 12, 13 or 14 is written with wb_data_o;
  - any other index is ignored and produces no error.
- Interrupt entry (intr_i=1): EPC <= epc_i, Cause <= cause_i, Status[0] <= 0. Status[31:1] is unchanged.
- eret_i=1: Status[0] <= 1. EPC and Cause are unchanged.
- Priority within a cycle, highest first: rst, intr_i, eret_i, mtc0.
  - intr_i wins over an mtc0 to the same register, and over eret_i on Status[0].
  - An mtc0 to a register untouched by intr_i or eret_i in that cycle still commits. Example: intr_i together with mtc0 to Status writes Status[31:1] from wb_data_o and clears Status[0].
- A GPR write is independent of intr_i and eret_i and always commits.
- Read ports: rs_data_o, rt_data_o and c0_rdata_o are combinational from the array. Same-cycle forwarding follows ## Configuration.

## Timing
- Reset: every GPR, Status, Cause and EPC becomes 0x0000_0000 on the first posedge with rst=1.
  - Outputs after reset: rs_data_o = rt_data_o = c0_rdata_o = status_o = epc_o = 0, intr_en_o = 0.
  - wb_data_o stays combinational from its inputs.
- rst asserted in the same cycle as a write or intr_i: reset wins and nothing commits.
- Write latency: a committed value is visible on read ports and status_o/epc_o in the cycle after the posedge, or the same cycle when bypass is enabled (GPR/c0 reads only).
- No stalls and no handshakes. Every cycle with RegWrite_i=1 commits.

## Configuration
- WB_BYPASS_EN defined:
  - rs_data_o / rt_data_o return wb_data_o when RegWrite_i, Rd_i[5]==0, the address matches, and the address is nonzero.
  - c0_rdata_o returns wb_data_o when RegWrite_i, Rd_i[5]==1 and Rd_i[4:0]==c0_addr_i for an implemented index. Bypass applies to mtc0 data only, never to intr_i values.
- WB_BYPASS_EN undefined: read ports return array contents only. A same-cycle write becomes visible one cycle later. Decode-stage forwarding or stalls cover the gap.

## Test plan
- Reset, then read all 32 GPRs and c0 12/13/14 -> all 0, intr_en_o=0.
- RegWrite_i=1, Rd_i=6'h05, RegData_i=01, MemData_i=0xDEADBEEF -> GPR5=0xDEADBEEF next cycle. Write to Rd_i=6'h00 with ALUResult_i=0x1234 -> GPR0 reads 0.
- mfc0_i=1, c0Data_i=0xCAFE0001, Rd_i=6'h08, RegData_i=01 -> GPR8=0xCAFE0001.
- mtc0 Rd_i=6'h2C (Status), ALUResult_i=0x0000_FF01 -> status_o=0xFF01, intr_en_o=1. Then intr_i with epc_i=0x0040_0010, cause_i=0x20 -> EPC=0x00400010, Cause=0x20, status_o=0xFF00. Then eret_i -> status_o=0xFF01.
- Same cycle: intr_i with epc_i=0x100, and mtc0 to EPC (Rd_i=6'h2E) with 0x200 -> EPC=0x100.
- rs_addr_i=5 while writing GPR5=0x77 -> rs_data_o=0x77 same cycle with WB_BYPASS_EN, old value without it. Both builds read 0x77 the next cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register state.
//   Selects the write-back value from the MEM/WB outputs and commits it either
//   to the 32-entry GPR file (Rd_i[5]=0) or to coprocessor-0 (Rd_i[5]=1;
//   implemented indices 12 Status, 13 Cause, 14 EPC). Interrupt entry and
//   eret update Status/Cause/EPC.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   RegWrite_i          write-back enable
//   RegData_i           source select (01 memory, else ALU)
//   ALUResult_i         ALU result
//   MemData_i           load data
//   Rd_i                destination (bit5 selects c0)
//   c0Data_i, mfc0_i    mfc0 value and override select
//   rs_addr_i/rt_addr_i GPR read addresses
//   c0_addr_i           c0 read address
//   intr_i, epc_i, cause_i  interrupt entry strobe and captured values
//   eret_i              exception-return strobe
//   rs_data_o/rt_data_o GPR read data (combinational)
//   c0_rdata_o          c0 read data, 0 for unimplemented indices
//   wb_data_o           selected write-back value
//   status_o, epc_o     current Status / EPC
//   intr_en_o           Status[0]
// Optional feature: define WB_BYPASS_EN to forward same-cycle writes to the
//   GPR and c0 read ports.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i,
  input  logic [1:0]  RegData_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [5:0]  Rd_i,
  input  logic [31:0] c0Data_i,
  input  logic        mfc0_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  c0_addr_i,
  input  logic        intr_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] cause_i,
  input  logic        eret_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] c0_rdata_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] status_o,
  output logic [31:0] epc_o,
  output logic        intr_en_o
);

  logic [31:0] gpr_q [32];
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;

  logic gpr_we, c0_we;
  logic [31:0] c0_arr;

  always_comb begin
    if (mfc0_i)                 wb_data_o = c0Data_i;
    else if (RegData_i == 2'b01) wb_data_o = MemData_i;
    else                        wb_data_o = ALUResult_i;
  end

  assign gpr_we = RegWrite_i && !Rd_i[5] && (Rd_i[4:0] != 5'd0);
  assign c0_we  = RegWrite_i && Rd_i[5];

  // mtc0 is applied first, then eret and intr override only the fields they
  // own; Status[31:1] from an mtc0 survives an intr/eret in the same cycle.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (c0_we) begin
      case (Rd_i[4:0])
        5'd12:   status_d = wb_data_o;
        5'd13:   cause_d  = wb_data_o;
        5'd14:   epc_d    = wb_data_o;
        default: ;
      endcase
    end
    if (intr_i) begin
      status_d[0] = 1'b0;
      cause_d     = cause_i;
      epc_d       = epc_i;
    end else if (eret_i) begin
      status_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) gpr_q[i] <= '0;
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      if (gpr_we) gpr_q[Rd_i[4:0]] <= wb_data_o;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    case (c0_addr_i)
      5'd12:   c0_arr = status_q;
      5'd13:   c0_arr = cause_q;
      5'd14:   c0_arr = epc_q;
      default: c0_arr = '0;
    endcase
  end

`ifdef WB_BYPASS_EN
  logic c0_impl;
  assign c0_impl = (c0_addr_i == 5'd12) || (c0_addr_i == 5'd13) || (c0_addr_i == 5'd14);

  always_comb begin
    rs_data_o = (rs_addr_i == 5'd0) ? '0 : gpr_q[rs_addr_i];
    rt_data_o = (rt_addr_i == 5'd0) ? '0 : gpr_q[rt_addr_i];
    if (gpr_we && (Rd_i[4:0] == rs_addr_i)) rs_data_o = wb_data_o;
    if (gpr_we && (Rd_i[4:0] == rt_addr_i)) rt_data_o = wb_data_o;
    c0_rdata_o = c0_arr;
    if (c0_we && c0_impl && (Rd_i[4:0] == c0_addr_i)) c0_rdata_o = wb_data_o;
  end
`else
  always_comb begin
    rs_data_o  = (rs_addr_i == 5'd0) ? '0 : gpr_q[rs_addr_i];
    rt_data_o  = (rt_addr_i == 5'd0) ? '0 : gpr_q[rt_addr_i];
    c0_rdata_o = c0_arr;
  end
`endif

  assign status_o  = status_q;
  assign epc_o     = epc_q;
  assign intr_en_o = status_q[0];

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_i;
  logic [1:0]  RegData_i;
  logic [31:0] ALUResult_i, MemData_i, c0Data_i, epc_i, cause_i;
  logic [5:0]  Rd_i;
  logic        mfc0_i, intr_i, eret_i;
  logic [4:0]  rs_addr_i, rt_addr_i, c0_addr_i;
  logic [31:0] rs_data_o, rt_data_o, c0_rdata_o, wb_data_o, status_o, epc_o;
  logic        intr_en_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .RegWrite_i(RegWrite_i), .RegData_i(RegData_i),
    .ALUResult_i(ALUResult_i), .MemData_i(MemData_i),
    .Rd_i(Rd_i), .c0Data_i(c0Data_i), .mfc0_i(mfc0_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .c0_addr_i(c0_addr_i),
    .intr_i(intr_i), .epc_i(epc_i), .cause_i(cause_i), .eret_i(eret_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .c0_rdata_o(c0_rdata_o),
    .wb_data_o(wb_data_o), .status_o(status_o), .epc_o(epc_o),
    .intr_en_o(intr_en_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  rsel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [5:0]  rd;
    logic [31:0] c0d;
    logic        mfc0;
    logic        intr;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        eret;
    logic [4:0]  raddr;
    logic [4:0]  c0a;
    logic [31:0] e_wb;
    logic [31:0] e_r;
    logic [31:0] e_c0;
    logic [31:0] e_st;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs [15];

  task automatic idle_inputs();
    RegWrite_i = 0; RegData_i = 0; ALUResult_i = 0; MemData_i = 0;
    Rd_i = 0; c0Data_i = 0; mfc0_i = 0; intr_i = 0; epc_i = 0;
    cause_i = 0; eret_i = 0;
  endtask

  initial begin
    // rw rsel alu mem rd c0d mfc0 intr epc cause eret raddr c0a | wb r c0 status epc
    vecs[0]  = '{1'b1, 2'b01, 32'h1111, 32'hDEADBEEF, 6'h05, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd12,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 2'b00, 32'h1234, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd13,
                 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 2'b01, 32'h0, 32'h5555, 6'h08, 32'hCAFE0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd8, 5'd14,
                 32'hCAFE0001, 32'hCAFE0001, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 2'b10, 32'hA5A5, 32'h9999, 6'h09, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd9, 5'd12,
                 32'hA5A5, 32'hA5A5, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 2'b00, 32'hFF01, 32'h0, 6'h2C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd12,
                 32'hFF01, 32'hDEADBEEF, 32'hFF01, 32'hFF01, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 32'h0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 32'h00400010, 32'h20, 1'b0, 5'd8, 5'd13,
                 32'h0, 32'hCAFE0001, 32'h20, 32'hFF00, 32'h00400010};
    vecs[6]  = '{1'b0, 2'b00, 32'h0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd14,
                 32'h0, 32'hA5A5, 32'h00400010, 32'hFF01, 32'h00400010};
    vecs[7]  = '{1'b1, 2'b00, 32'h200, 32'h0, 6'h2E, 32'h0, 1'b0, 1'b1, 32'h100, 32'h33, 1'b0, 5'd0, 5'd14,
                 32'h200, 32'h0, 32'h100, 32'hFF00, 32'h100};
    vecs[8]  = '{1'b1, 2'b00, 32'hABCD0003, 32'h0, 6'h2C, 32'h0, 1'b0, 1'b1, 32'h104, 32'h44, 1'b0, 5'd5, 5'd12,
                 32'hABCD0003, 32'hDEADBEEF, 32'hABCD0002, 32'hABCD0002, 32'h104};
    vecs[9]  = '{1'b1, 2'b00, 32'h1230, 32'h0, 6'h2C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd13,
                 32'h1230, 32'hDEADBEEF, 32'h44, 32'h1231, 32'h104};
    vecs[10] = '{1'b1, 2'b00, 32'h7777, 32'h0, 6'h2D, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd13,
                 32'h7777, 32'hDEADBEEF, 32'h7777, 32'h1231, 32'h104};
    vecs[11] = '{1'b1, 2'b00, 32'hBAD, 32'h0, 6'h2F, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd15, 5'd15,
                 32'hBAD, 32'h0, 32'h0, 32'h1231, 32'h104};
    vecs[12] = '{1'b0, 2'b00, 32'h0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 32'h300, 32'h55, 1'b1, 5'd5, 5'd13,
                 32'h0, 32'hDEADBEEF, 32'h55, 32'h1230, 32'h300};
    vecs[13] = '{1'b1, 2'b00, 32'h3333, 32'h0, 6'h03, 32'h0, 1'b0, 1'b1, 32'h400, 32'h66, 1'b0, 5'd3, 5'd13,
                 32'h3333, 32'h3333, 32'h66, 32'h1230, 32'h400};
    vecs[14] = '{1'b0, 2'b00, 32'hEEEE, 32'h0, 6'h06, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd6, 5'd14,
                 32'hEEEE, 32'h0, 32'h400, 32'h1230, 32'h400};

    // Reset and sweep every readable location.
    idle_inputs();
    rs_addr_i = 0; rt_addr_i = 0; c0_addr_i = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 32; i++) begin
      rs_addr_i = 5'(i); rt_addr_i = 5'(31 - i);
      #1;
      check($sformatf("reset_rs[%0d]", i), rs_data_o, 32'h0);
      check($sformatf("reset_rt[%0d]", 31 - i), rt_data_o, 32'h0);
    end
    for (int i = 12; i < 15; i++) begin
      c0_addr_i = 5'(i);
      #1 check($sformatf("reset_c0[%0d]", i), c0_rdata_o, 32'h0);
    end
    check("reset_status", status_o, 32'h0);
    check("reset_epc", epc_o, 32'h0);
    check("reset_intr_en", {31'h0, intr_en_o}, 32'h0);

    // Table-driven vectors: wb checked before the edge, state after it.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      RegWrite_i = vecs[i].rw;   RegData_i = vecs[i].rsel;
      ALUResult_i = vecs[i].alu; MemData_i = vecs[i].mem;
      Rd_i = vecs[i].rd;         c0Data_i = vecs[i].c0d;
      mfc0_i = vecs[i].mfc0;     intr_i = vecs[i].intr;
      epc_i = vecs[i].epc;       cause_i = vecs[i].cause;
      eret_i = vecs[i].eret;
      rs_addr_i = vecs[i].raddr; rt_addr_i = vecs[i].raddr;
      c0_addr_i = vecs[i].c0a;
      #1 check($sformatf("v%0d_wb", i), wb_data_o, vecs[i].e_wb);
      @(posedge clk);
      #1 idle_inputs();
      #1;
      check($sformatf("v%0d_rs", i), rs_data_o, vecs[i].e_r);
      check($sformatf("v%0d_rt", i), rt_data_o, vecs[i].e_r);
      check($sformatf("v%0d_c0", i), c0_rdata_o, vecs[i].e_c0);
      check($sformatf("v%0d_status", i), status_o, vecs[i].e_st);
      check($sformatf("v%0d_epc", i), epc_o, vecs[i].e_epc);
      check($sformatf("v%0d_intr_en", i), {31'h0, intr_en_o}, {31'h0, vecs[i].e_st[0]});
    end

    // Same-cycle GPR read while writing GPR5 = 0x77.
    @(negedge clk);
    RegWrite_i = 1; ALUResult_i = 32'h77; Rd_i = 6'h05;
    rs_addr_i = 5'd5; rt_addr_i = 5'd5;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_rs_same", rs_data_o, 32'h77);
    check("byp_rt_same", rt_data_o, 32'h77);
`else
    check("byp_rs_same", rs_data_o, 32'hDEADBEEF);
    check("byp_rt_same", rt_data_o, 32'hDEADBEEF);
`endif
    @(posedge clk);
    #1 idle_inputs();
    #1 check("byp_rs_next", rs_data_o, 32'h77);

    // Same-cycle c0 read while writing Cause = 0x88; intr values never bypass.
    @(negedge clk);
    RegWrite_i = 1; ALUResult_i = 32'h88; Rd_i = 6'h2D; c0_addr_i = 5'd13;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_c0_same", c0_rdata_o, 32'h88);
`else
    check("byp_c0_same", c0_rdata_o, 32'h66);
`endif
    @(posedge clk);
    #1 idle_inputs();
    c0_addr_i = 5'd14; intr_i = 1; epc_i = 32'h999;
    #1 check("intr_no_bypass", c0_rdata_o, 32'h400);
    check("c0_cause_next", dut.cause_q, 32'h88);
    @(posedge clk);
    #1 idle_inputs();
    #1 check("intr_epc_next", epc_o, 32'h999);

    // Reset wins over a simultaneous GPR write, mtc0 and intr.
    @(negedge clk);
    rst = 1; RegWrite_i = 1; ALUResult_i = 32'h5A5A; Rd_i = 6'h07;
    intr_i = 1; epc_i = 32'hABC; cause_i = 32'h1;
    @(posedge clk);
    #1 rst = 0; idle_inputs();
    rs_addr_i = 5'd7; rt_addr_i = 5'd5; c0_addr_i = 5'd13;
    #1;
    check("rstwin_gpr7", rs_data_o, 32'h0);
    check("rstwin_gpr5", rt_data_o, 32'h0);
    check("rstwin_cause", c0_rdata_o, 32'h0);
    check("rstwin_epc", epc_o, 32'h0);
    check("rstwin_status", status_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
